// File: rtl/aes_pkg.sv
// Shared AES datapath types and sizes.
// Byte k of a state occupies bits [8k+7:8k].
package aes_pkg;
  localparam int AES_BLOCK_W   = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_BYTES = 16;

  typedef logic [AES_BYTE_W-1:0] byte_t;
  typedef logic [AES_NUM_BYTES-1:0][AES_BYTE_W-1:0] state_t;
endpackage

// File: rtl/aes_inv_sub_bytes_if.sv
// State bus into and out of the InvSubBytes stage.
// master drives state_in; slave drives state_out.
interface aes_inv_sub_bytes_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic [AES_BLOCK_W-1:0] state_in;
  logic                   out_valid;
  logic [AES_BLOCK_W-1:0] state_out;

  modport master (
    output in_valid,
    output state_in,
    input  out_valid,
    input  state_out
  );

  modport slave (
    input  in_valid,
    input  state_in,
    output out_valid,
    output state_out
  );
endinterface

// File: rtl/aes_inv_sbox.sv
// FIPS-197 inverse S-box, one byte, purely combinational.
// Rows of the table are indexed by the high nibble.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t y
);
  always_comb begin
    y = 8'h00;
    case (a)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5;
      8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e;
      8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82;
      8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44;
      8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32;
      8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b;
      8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66;
      8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49;
      8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64;
      8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc;
      8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50;
      8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57;
      8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00;
      8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05;
      8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f;
      8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03;
      8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41;
      8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce;
      8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22;
      8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8;
      8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71;
      8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e;
      8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b;
      8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe;
      8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33;
      8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59;
      8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9;
      8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f;
      8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d;
      8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c;
      8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e;
      8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63;
      8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
      default: y = 8'h00;
    endcase
  end
endmodule

// File: rtl/aes_inv_sub_bytes.sv
// AES InvSubBytes stage: 16 parallel inverse S-boxes feeding
// one output register, one-cycle latency, no backpressure.
module aes_inv_sub_bytes
  import aes_pkg::*;
(
  input logic clk,
  input logic rst,
  aes_inv_sub_bytes_if.slave bus
);
  state_t s_in;
  state_t s_sub;

  assign s_in = bus.state_in;

  for (genvar k = 0; k < AES_NUM_BYTES; k++) begin : g_lane
    aes_inv_sbox u_sbox (
      .a (s_in[k]),
      .y (s_sub[k])
    );
  end

  // The state register only loads on valid, so idle X inputs never reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.state_out <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.state_out <= s_sub;
      end
    end
  end
endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Directed bench for aes_inv_sub_bytes with an independent
// forward S-box (GF(2^8) inverse + affine) for round-trip checks.
module tb_aes_inv_sub_bytes;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] fwd [256];

  aes_inv_sub_bytes_if bus ();

  aes_inv_sub_bytes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, v);
    return r ^ rol(r, 1) ^ rol(r, 2) ^ rol(r, 3) ^ rol(r, 4) ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string tag, input logic [127:0] vin,
                       input logic [127:0] exp);
    bus.in_valid = 1'b1;
    bus.state_in = vin;
    tick();
    chk({tag, "_valid"}, {127'd0, bus.out_valid}, 128'd1);
    chk(tag, bus.state_out, exp);
  endtask

  localparam logic [127:0] KV_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] KV_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

  initial begin
    logic [127:0] rt;
    logic [127:0] exp_rt;
    logic [7:0]   b;

    for (int i = 0; i < 256; i++) fwd[i] = fwd_sbox(8'(i));

    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.state_in = '1;
    tick();
    chk("rst1_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst1_state", bus.state_out, 128'h0);
    tick();
    chk("rst2_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst2_state", bus.state_out, 128'h0);

    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.state_in = '0;
    tick();
    chk("idle_valid", {127'd0, bus.out_valid}, 128'd0);

    apply("known", KV_IN, KV_OUT);
    bus.in_valid = 1'b0;
    bus.state_in = 'x;
    tick();
    chk("hold_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("hold_state", bus.state_out, KV_OUT);
    tick();
    chk("hold_x_state", bus.state_out, KV_OUT);

    apply("all00", {16{8'h00}}, {16{8'h52}});
    apply("all63", {16{8'h63}}, {16{8'h00}});
    apply("allff", {16{8'hff}}, {16{8'h7d}});
    apply("all01", {16{8'h01}}, {16{8'h09}});
    apply("lanes", 128'h000102030405060708090a0b0c0d0e0f,
          128'h52096ad53036a538bf40a39e81f3d7fb);

    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      bus.in_valid = 1'b1;
      bus.state_in = {16{b}};
      tick();
      chk("stream_valid", {127'd0, bus.out_valid}, 128'd1);
      for (int k = 0; k < 16; k++) rt[8*k +: 8] = fwd[bus.state_out[8*k +: 8]];
      exp_rt = {16{b}};
      chk("stream_roundtrip", rt, exp_rt);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_end_valid", {127'd0, bus.out_valid}, 128'd0);

    apply("burst1", {16{8'h10}}, {16{8'h7c}});
    apply("burst2", {16{8'h7a}}, {16{8'hbd}});
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.state_in = {16{8'h9f}};
    tick();
    chk("midrst_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("midrst_state", bus.state_out, 128'h0);
    rst = 1'b0;
    apply("post_rst", KV_IN, KV_OUT);
    bus.in_valid = 1'b0;
    tick();
    chk("post_rst_idle", {127'd0, bus.out_valid}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
